// File: rtl/wb_regfile.sv
// Writeback stage and 8 x 16-bit architectural register file with debug counters.
// Optional feature: define WB_BYPASS_EN for same-cycle write-before-read bypass.
module wb_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_mem_in,
    input  logic [15:0] aluResIn,
    input  logic [2:0]  writeRegIn,
    input  logic        MemToRegIn,
    input  logic        RegWriteIn,
    input  logic        writeRegValidIn,
    input  logic [2:0]  readReg1,
    input  logic [2:0]  readReg2,
    output logic [15:0] readData1,
    output logic [15:0] readData2,
    output logic [15:0] wbData,
    output logic [15:0] wbCount,
    output logic        wbErr
);

    logic [15:0] regs [8];
    logic        we;
    logic        malformed;

    assign wbData    = MemToRegIn ? data_mem_in : aluResIn;
    assign we        = RegWriteIn & writeRegValidIn;
    assign malformed = RegWriteIn & ~writeRegValidIn;

    // NOTE: the array is reset because decode must read zeros right after reset,
    // so it maps to flops rather than a RAM macro; non-blocking keeps every
    // register update ordered against the same clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
        end else if (we) begin
            regs[writeRegIn] <= wbData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbCount <= 16'h0000;
            wbErr   <= 1'b0;
        end else begin
            if (we)        wbCount <= wbCount + 16'h0001;
            if (malformed) wbErr   <= 1'b1;
        end
    end

    // NOTE: both read outputs get a value on every path, so no latch is inferred.
    always_comb begin
        readData1 = regs[readReg1];
        readData2 = regs[readReg2];
`ifdef WB_BYPASS_EN
        if (we && (readReg1 == writeRegIn)) readData1 = wbData;
        if (we && (readReg2 == writeRegIn)) readData2 = wbData;
`else
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected values, a negedge
// monitor pops and compares them. Works with or without WB_BYPASS_EN.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_mem_in;
    logic [15:0] aluResIn;
    logic [2:0]  writeRegIn;
    logic        MemToRegIn;
    logic        RegWriteIn;
    logic        writeRegValidIn;
    logic [2:0]  readReg1;
    logic [2:0]  readReg2;
    logic [15:0] readData1;
    logic [15:0] readData2;
    logic [15:0] wbData;
    logic [15:0] wbCount;
    logic        wbErr;

    wb_regfile dut (
        .clk             (clk),
        .rst             (rst),
        .data_mem_in     (data_mem_in),
        .aluResIn        (aluResIn),
        .writeRegIn      (writeRegIn),
        .MemToRegIn      (MemToRegIn),
        .RegWriteIn      (RegWriteIn),
        .writeRegValidIn (writeRegValidIn),
        .readReg1        (readReg1),
        .readReg2        (readReg2),
        .readData1       (readData1),
        .readData2       (readData2),
        .wbData          (wbData),
        .wbCount         (wbCount),
        .wbErr           (wbErr)
    );

    always #5 clk = ~clk;

    typedef enum int { S_RD1, S_RD2, S_WBDATA, S_COUNT, S_ERR } sel_t;

    typedef struct {
        string       name;
        sel_t        sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every queued expectation is compared at the next falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [15:0] act;
            e = sb.pop_front();
            case (e.sel)
                S_RD1:    act = readData1;
                S_RD2:    act = readData2;
                S_WBDATA: act = wbData;
                S_COUNT:  act = wbCount;
                default:  act = {15'd0, wbErr};
            endcase
            check(e.name, act, e.exp);
        end
    end

    task automatic expect_val(input sel_t sel, input string name, input logic [15:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWriteIn      = 1'b0;
        writeRegValidIn = 1'b0;
    endtask

    task automatic write_alu(input logic [2:0] idx, input logic [15:0] val);
        MemToRegIn      = 1'b0;
        aluResIn        = val;
        writeRegIn      = idx;
        RegWriteIn      = 1'b1;
        writeRegValidIn = 1'b1;
        step();
        idle();
    endtask

    logic [15:0] same_cycle_exp;

    initial begin
        // Reset held while a write to r3 is presented.
        rst             = 1'b0;
        data_mem_in     = 16'h0000;
        aluResIn        = 16'h1234;
        writeRegIn      = 3'd3;
        MemToRegIn      = 1'b0;
        RegWriteIn      = 1'b1;
        writeRegValidIn = 1'b1;
        readReg1        = 3'd0;
        readReg2        = 3'd0;
        #1;
        for (int i = 0; i < 8; i++) begin
            readReg1 = 3'(i);
            readReg2 = 3'(7 - i);
            expect_val(S_RD1, "reset_rd1", 16'h0000);
            expect_val(S_RD2, "reset_rd2", 16'h0000);
            if (i == 0) begin
                expect_val(S_WBDATA, "reset_wbdata_comb", 16'h1234);
                expect_val(S_COUNT,  "reset_count", 16'h0000);
                expect_val(S_ERR,    "reset_err", 16'h0000);
            end
            step();
        end
        idle();
        step();
        rst      = 1'b1;
        readReg1 = 3'd3;
        readReg2 = 3'd3;
        step();
        expect_val(S_RD1,   "post_reset_r3", 16'h0000);
        expect_val(S_COUNT, "post_reset_count", 16'h0000);
        expect_val(S_ERR,   "post_reset_err", 16'h0000);
        step();

        // ALU writeback to r5.
        write_alu(3'd5, 16'hBEEF);
        readReg1 = 3'd5;
        expect_val(S_RD1,   "alu_wb_r5", 16'hBEEF);
        expect_val(S_COUNT, "alu_wb_count", 16'd1);
        step();

        // Load writeback to r7; ALU result must be ignored.
        MemToRegIn      = 1'b1;
        data_mem_in     = 16'h00A5;
        aluResIn        = 16'hFFFF;
        writeRegIn      = 3'd7;
        RegWriteIn      = 1'b1;
        writeRegValidIn = 1'b1;
        readReg2        = 3'd7;
        expect_val(S_WBDATA, "load_wbdata_comb", 16'h00A5);
        step();
        idle();
        MemToRegIn = 1'b0;
        expect_val(S_RD2,    "load_wb_r7", 16'h00A5);
        expect_val(S_WBDATA, "alu_select_comb", 16'hFFFF);
        expect_val(S_COUNT,  "load_wb_count", 16'd2);
        step();

        // Same-cycle read of the write target.
        write_alu(3'd2, 16'h1111);
        aluResIn        = 16'h2222;
        writeRegIn      = 3'd2;
        RegWriteIn      = 1'b1;
        writeRegValidIn = 1'b1;
        readReg1        = 3'd2;
        readReg2        = 3'd2;
`ifdef WB_BYPASS_EN
        same_cycle_exp = 16'h2222;
`else
        same_cycle_exp = 16'h1111;
`endif
        expect_val(S_RD1, "same_cycle_rd1", same_cycle_exp);
        expect_val(S_RD2, "same_cycle_rd2", same_cycle_exp);
        step();
        idle();
        expect_val(S_RD1,   "next_cycle_rd1", 16'h2222);
        expect_val(S_RD2,   "next_cycle_rd2", 16'h2222);
        expect_val(S_COUNT, "same_cycle_count", 16'd4);
        step();

        // Malformed writeback to r4 (preloaded to 0x4444).
        write_alu(3'd4, 16'h4444);
        aluResIn        = 16'h9999;
        writeRegIn      = 3'd4;
        RegWriteIn      = 1'b1;
        writeRegValidIn = 1'b0;
        readReg1        = 3'd4;
        step();
        idle();
        expect_val(S_RD1,   "malformed_r4_kept", 16'h4444);
        expect_val(S_COUNT, "malformed_count_kept", 16'd5);
        expect_val(S_ERR,   "malformed_err_set", 16'h0001);
        step();
        repeat (10) step();
        expect_val(S_ERR, "err_sticky_10_idle", 16'h0001);
        step();
        rst = 1'b0;
        #1;
        expect_val(S_ERR,   "err_cleared_async", 16'h0000);
        expect_val(S_COUNT, "count_cleared_async", 16'h0000);
        expect_val(S_RD1,   "r4_cleared_async", 16'h0000);
        step();
        rst = 1'b1;
        step();

        // Counter wrap: 65535 writes, then one more.
        MemToRegIn      = 1'b0;
        aluResIn        = 16'h0F0F;
        writeRegIn      = 3'd0;
        RegWriteIn      = 1'b1;
        writeRegValidIn = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        idle();
        expect_val(S_COUNT, "count_ffff", 16'hFFFF);
        step();
        write_alu(3'd1, 16'h0001);
        readReg1 = 3'd0;
        expect_val(S_COUNT, "count_wrap_zero", 16'h0000);
        expect_val(S_RD1,   "r0_writable", 16'h0F0F);
        step();

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the five-stage pipeline. Consumes MEM/WB pipeline register outputs, selects the writeback value (memory data or ALU result), and commits it to an 8 x 16-bit register file. Provides the two combinational read ports used by decode. Also keeps a committed-write counter and a sticky malformed-writeback flag for debug.

## Interface
- Parameters: none; data width fixed at 16, register count fixed at 8.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_mem_in  input  16  load data from MEM/WB.
- aluResIn  input  16  ALU result from MEM/WB.
- writeRegIn  input  3  destination register index.
- MemToRegIn  input  1  1 = write back data_mem_in, 0 = write back aluResIn.
- RegWriteIn  input  1  writeback requested.
- writeRegValidIn  input  1  destination index is meaningful.
- readReg1, readReg2  input  3  decode read indices.
- readData1, readData2  output  16  register contents, combinational.
- wbData  output  16  selected writeback value, combinational.
- wbCount  output  16  number of committed register writes.
- wbErr  output  1  sticky: RegWriteIn seen without writeRegValidIn.

## Operation
- wbData = MemToRegIn ? data_mem_in : aluResIn, independent of write enable.
- Write enable we = RegWriteIn & writeRegValidIn.
- When we is high on a rising clk edge, reg[writeRegIn] <= wbData. All 8 registers are writable; r0 is not hardwired.
- Reads are combinational: readDataN = reg[readRegN]. Both ports may address the same register or the write target in the same cycle.
- wbCount increments by 1 on each edge with we = 1, and wraps from 0xFFFF to 0x0000.
- If RegWriteIn = 1 and writeRegValidIn = 0 on an edge, wbErr sets and holds until reset. The write is suppressed and wbCount is unchanged.
- No state machine. State consists of the register array, wbCount and wbErr.

## Timing
- Reset, asserted low and asynchronous: all 8 registers go to 0x0000, wbCount to 0, wbErr to 0.
  - readData1 and readData2 read 0x0000 while reset is held and immediately after release.
  - wbData stays combinational through reset.
- Reset asserted in the same cycle as a write: reset wins and the write is lost.
- Write latency: the new value is visible on read ports on the cycle after the commit edge (unless bypass is enabled; see Configuration).
- wbCount and wbErr change only on rising edges, except for the asynchronous clear.
- Inputs are sampled only at the edge; mid-cycle glitches on MEM/WB outputs have no effect.

## Configuration
- WB_BYPASS_EN defined: write-before-read bypass.
  - When we = 1 and readRegN == writeRegIn, readDataN = wbData in the same cycle.
  - Decode therefore sees the value being written back with zero added latency. Applies to both ports independently.
- WB_BYPASS_EN undefined: read ports always return stored contents. A same-cycle read of the write target returns the old value, and the hazard logic must stall one extra cycle.

## Test plan
- Reset: hold rst=0 with we=1, writeReg=3 and aluRes=0x1234, then release.
  - Required: all reads 0x0000, wbCount=0, wbErr=0, r3 not written.
- ALU writeback: MemToReg=0, aluRes=0xBEEF, writeReg=5, RegWrite=1, valid=1 for one edge; then readReg1=5.
  - Required: readData1=0xBEEF next cycle, wbCount=1.
- Load writeback with ALU ignored: MemToReg=1, data_mem=0x00A5, aluRes=0xFFFF, writeReg=7.
  - Required: wbData=0x00A5 combinationally, r7=0x00A5 after the edge.
- Same-cycle read of write target: writeReg=2 holding 0x1111, new value 0x2222, readReg1=readReg2=2.
  - Required: both ports show 0x2222 in the same cycle with WB_BYPASS_EN, and 0x1111 without it (0x2222 on the next cycle).
- Malformed writeback: RegWrite=1, valid=0, writeReg=4, aluRes=0x9999.
  - Required: r4 unchanged, wbCount unchanged, wbErr=1 and still 1 after 10 idle cycles; cleared only by rst=0.
- Counter wrap: preload by issuing 65535 valid writes, then one more.
  - Required: wbCount reads 0xFFFF, then 0x0000.
